fan_sel_gen: RTL
================

# fan_sel_gen

Control-side producer for the fan adder in the sparse tensor core datapath. It accepts a stream of sparse-block metadata: a NUM_IN-bit nonzero mask plus a mode bit. It expands each block into one or more fan-adder command beats carrying `add_en`, `bypass_en` and `sel`. Blocks with more nonzeros than output lanes are split across several beats. Sits between the metadata decoder and the fan adder's control inputs, with valid/ready on both sides.

## Interface
- NUM_IN, 4, input lanes of the fan adder (mask width)
- NUM_OUT, 2, output lanes (selectors per beat)
- SEL_IN, 2, selector width; must equal $clog2(NUM_IN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  metadata beat valid
- in_ready  out  1  metadata beat accepted when both high
- in_mask  in  NUM_IN  nonzero bitmap of the sparse block
- in_mode  in  1  0 = bypass (distribute), 1 = add (reduce)
- out_valid  out  1  command beat valid
- out_ready  in  1  fan adder consumes beat
- add_en  out  1  equals captured mode
- bypass_en  out  1  equals inverse of captured mode while out_valid; 0 otherwise
- sel  out  SEL_IN*NUM_OUT  lane k selector at bits [k*SEL_IN +: SEL_IN]
- lane_vld  out  NUM_OUT  lane k selector is meaningful
- out_first  out  1  first beat of the block
- out_last  out  1  last beat of the block

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: `in_ready`=1. On handshake, capture mask into `rem_mask` and mode into the mode register, then go to ISSUE.
- ISSUE: present the current beat, built combinationally from `rem_mask`:
  - Lane k = index of the (k+1)-th lowest set bit of `rem_mask`, lowest index on lane 0.
  - Lanes beyond the popcount: sel=0, lane_vld=0.
- On an out handshake:
  - Clear the picked bits from `rem_mask`.
  - `out_first` drops.
  - If the beat was `out_last`, return to IDLE, or stay in ISSUE if a new block is accepted in the same cycle.
- `out_last` = popcount(`rem_mask`) ≤ NUM_OUT.
- Beats per block = max(1, ceil(popcount/NUM_OUT)).
- Empty mask yields exactly one beat: lane_vld=0, first=last=1. Framing is preserved.
- `add_en`/`bypass_en` are 0 whenever `out_valid`=0. They are never both 1.
- Reset mid-block discards `rem_mask`; no partial beat is emitted afterwards.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - add_en=0, bypass_en=0
  - sel=0, lane_vld=0
  - out_first=0, out_last=0
  - FSM=IDLE
- Latency: a block accepted in cycle N gives `out_valid`=1 in cycle N+1.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one beat per cycle. Back-to-back single-beat blocks sustain 1 block/cycle. `in_ready` = IDLE || (out_valid && out_ready && out_last).
- A stall on `out_ready` back-pressures `in_ready` in the same cycle (combinational path).

## Configuration
- `FAN_SEL_SKID_EN` defined:
  - Adds a 2-entry input skid buffer; `in_ready` is a register output (= skid not full). This removes the out_ready→in_ready path.
  - Latency becomes N+2 from an empty skid. Throughput is unchanged.
  - Reset empties the skid; `in_ready`=1.
- Undefined: behaviour exactly as in Timing.

## Structure
- Shared package `fan_pkg`:
  - Mode localparams MODE_BYPASS=1'b0, MODE_ADD=1'b1.
  - FSM state encoding.
  - popcount function.
- Sub-module `fan_pick_low`: combinational selection of the lowest NUM_OUT set bits of a mask. Outputs are the indices, lane valids and the cleared-mask remainder. Instantiated once.

## Test plan
- mask 4'b1010, mode 0, out_ready=1 → one beat: sel={2'd3,2'd1}, lane_vld=2'b11, bypass_en=1, add_en=0, first=last=1, one cycle after accept.
- mask 4'b1111, mode 1 → two beats: sel={2'd1,2'd0} with first=1,last=0, then sel={2'd3,2'd2} with first=0,last=1. add_en=1 on both. in_ready=0 between beats.
- mask 4'b0000 → one beat: lane_vld=2'b00, sel=0, first=last=1. mask 4'b0100 → sel={2'd0,2'd2}, lane_vld=2'b01.
- out_ready held 0 for 5 cycles during mask 4'b1111 → first beat outputs unchanged throughout. No bits are lost once ready returns.
- Back-to-back masks 4'b0011, 4'b1100, 4'b0001 with in_valid and out_ready constant 1 → three consecutive output beats, no bubbles. With `FAN_SEL_SKID_EN` defined, the same sequence with one extra cycle of initial latency.
- Assert rst during the first beat of 4'b1111 → outputs at reset values immediately. After release, the next accepted mask issues normally, with no residual second beat.

Source files
------------

// File: rtl/fan_sel_gen_pkg.sv
// fan_pkg: shared modes, FSM encoding and popcount for the fan adder selector generator
package fan_pkg;

    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_ADD    = 1'b1;

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic int popcount(input logic [31:0] v);
        popcount = 0;
        for (int i = 0; i < 32; i++) popcount += int'(v[i]);
    endfunction

endpackage

// File: rtl/fan_sel_gen_pick_low.sv
// fan_pick_low: picks the lowest NUM_OUT set bits of a mask, lowest index on lane 0
module fan_pick_low #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int SEL_IN  = 2
) (
    input  logic [NUM_IN-1:0]         mask,
    output logic [SEL_IN*NUM_OUT-1:0] sel,
    output logic [NUM_OUT-1:0]        vld,
    output logic [NUM_IN-1:0]         rem
);
    import fan_pkg::*;

    // scan upward, filling lanes in order and clearing each picked bit from the remainder
    always_comb begin
        int c;
        c = 0;
        sel = '0;
        vld = '0;
        rem = mask;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mask[i] && c < NUM_OUT) begin
                sel[c*SEL_IN +: SEL_IN] = SEL_IN'(i);
                vld[c] = 1'b1;
                rem[i] = 1'b0;
                c++;
            end
        end
    end

endmodule

// File: rtl/fan_sel_gen.sv
// fan_sel_gen: expands sparse-block masks into fan-adder command beats; FAN_SEL_SKID_EN adds a 2-entry input skid
module fan_sel_gen #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int SEL_IN  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN-1:0]         in_mask,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      add_en,
    output logic                      bypass_en,
    output logic [SEL_IN*NUM_OUT-1:0] sel,
    output logic [NUM_OUT-1:0]        lane_vld,
    output logic                      out_first,
    output logic                      out_last
);
    import fan_pkg::*;

    state_t                    state;
    logic [NUM_IN-1:0]         rem_mask;
    logic                      mode;
    logic                      first;
    logic [SEL_IN*NUM_OUT-1:0] pick_sel;
    logic [NUM_OUT-1:0]        pick_vld;
    logic [NUM_IN-1:0]         pick_rem;
    logic                      src_valid;
    logic [NUM_IN-1:0]         src_mask;
    logic                      src_mode;
    logic                      can_take;
    logic                      take;

    fan_pick_low #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_IN(SEL_IN)) u_pick (
        .mask(rem_mask),
        .sel (pick_sel),
        .vld (pick_vld),
        .rem (pick_rem)
    );

    assign out_valid = state == ISSUE;
    assign out_last  = out_valid && popcount(32'(rem_mask)) <= NUM_OUT;
    assign out_first = out_valid && first;
    assign add_en    = out_valid && mode == MODE_ADD;
    assign bypass_en = out_valid && mode == MODE_BYPASS;
    assign sel       = out_valid ? pick_sel : '0;
    assign lane_vld  = out_valid ? pick_vld : '0;
    assign can_take  = state == IDLE || (out_valid && out_ready && out_last);
    assign take      = src_valid && can_take;

`ifdef FAN_SEL_SKID_EN
    logic [NUM_IN:0] skid [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      cnt;
    logic [1:0]      cnt_nxt;
    logic            ready_r;
    logic            push;

    assign push      = in_valid && ready_r;
    assign cnt_nxt   = cnt + 2'(push) - 2'(take);
    assign in_ready  = ready_r;
    assign src_valid = cnt != 2'd0;
    assign {src_mode, src_mask} = skid[rd_ptr];

    // skid occupancy; ready is registered so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            rd_ptr  <= rd_ptr ^ take;
            wr_ptr  <= wr_ptr ^ push;
            ready_r <= cnt_nxt != 2'd2;
        end
    end

    // skid payload storage
    always_ff @(posedge clk) begin
        if (push) skid[wr_ptr] <= {in_mode, in_mask};
    end
`else
    assign src_valid = in_valid;
    assign src_mask  = in_mask;
    assign src_mode  = in_mode;
    assign in_ready  = can_take;
`endif

    // block capture and beat sequencing; a new block may load on the same edge the last beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem_mask <= '0;
            mode     <= MODE_BYPASS;
            first    <= 1'b0;
        end else if (take) begin
            state    <= ISSUE;
            rem_mask <= src_mask;
            mode     <= src_mode;
            first    <= 1'b1;
        end else if (out_valid && out_ready) begin
            rem_mask <= pick_rem;
            first    <= 1'b0;
            state    <= out_last ? IDLE : ISSUE;
        end
    end

endmodule
